// File: rtl/elevador_npisos.sv
// SCAN elevator controller for FLOORS floors: serves latched calls, stops on sensed floors, times the door.
// Outputs are registered; a stop decided on a sensor edge drops the motor one cycle later.
module elevador_npisos #(
    parameter int FLOORS      = 4,
    parameter int DOOR_CYCLES = 8,
    localparam int FW         = (FLOORS > 2) ? $clog2(FLOORS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLOORS-1:0] req,
    input  logic [FLOORS-1:0] fsens,
    output logic              mup,
    output logic              mdw,
    output logic              door_open,
    output logic [FW-1:0]     floor,
    output logic [FLOORS-1:0] pending,
    output logic              moving
);

    typedef enum logic [1:0] {S_IDLE, S_UP, S_DN, S_DOOR} state_t;

    state_t            state_q, state_d;
    logic              dir_q, dir_d;
    logic [7:0]        timer_q, timer_d;
    logic [FW-1:0]     floor_q, floor_d;
    logic [FLOORS-1:0] pending_q, pending_d;
    logic              mup_q, mup_d;
    logic              mdw_q, mdw_d;
    logic              door_q, door_d;

    logic              fs_vld;
    logic [FW-1:0]     fs_idx;
    logic [FW-1:0]     stop_flr;
    logic              enter_door;
    logic              above, below;

    function automatic logic [FW-1:0] onehot_idx(input logic [FLOORS-1:0] v);
        onehot_idx = '0;
        for (int i = 0; i < FLOORS; i++) begin
            if (v[i]) onehot_idx = FW'(i);
        end
    endfunction

    assign fs_vld = $onehot(fsens);
    assign fs_idx = onehot_idx(fsens);

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        timer_d    = timer_q;
        floor_d    = fs_vld ? fs_idx : floor_q;
        stop_flr   = floor_q;
        enter_door = 1'b0;
        above      = 1'b0;
        below      = 1'b0;

        for (int i = 0; i < FLOORS; i++) begin
            if (pending_q[i] && (i > int'(floor_q))) above = 1'b1;
            if (pending_q[i] && (i < int'(floor_q))) below = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (pending_q[floor_q]) begin
                    state_d    = S_DOOR;
                    timer_d    = 8'(DOOR_CYCLES);
                    enter_door = 1'b1;
                end else if (above && (dir_q || !below)) begin
                    state_d = S_UP;
                    dir_d   = 1'b1;
                end else if (below) begin
                    state_d = S_DN;
                    dir_d   = 1'b0;
                end
            end
            S_UP: begin
                // top floor always stops the cab, even with nothing pending there
                if (fs_vld && (pending_q[fs_idx] || (fs_idx == FW'(FLOORS - 1)))) begin
                    state_d    = S_DOOR;
                    timer_d    = 8'(DOOR_CYCLES);
                    stop_flr   = fs_idx;
                    enter_door = 1'b1;
                end
            end
            S_DN: begin
                if (fs_vld && (pending_q[fs_idx] || (fs_idx == '0))) begin
                    state_d    = S_DOOR;
                    timer_d    = 8'(DOOR_CYCLES);
                    stop_flr   = fs_idx;
                    enter_door = 1'b1;
                end
            end
            default: begin
                // a call at the open floor keeps the door open instead of queuing
                if (req[floor_q]) begin
                    timer_d = 8'(DOOR_CYCLES);
                end else if (timer_q <= 8'd1) begin
                    state_d = S_IDLE;
                    timer_d = 8'd0;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
        endcase

        pending_d = pending_q | req;
        if (enter_door || (state_q == S_DOOR)) pending_d[stop_flr] = 1'b0;

        mup_d  = (state_d == S_UP);
        mdw_d  = (state_d == S_DN);
        door_d = (state_d == S_DOOR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            dir_q     <= 1'b1;
            timer_q   <= 8'd0;
            floor_q   <= '0;
            pending_q <= '0;
            mup_q     <= 1'b0;
            mdw_q     <= 1'b0;
            door_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            timer_q   <= timer_d;
            floor_q   <= floor_d;
            pending_q <= pending_d;
            mup_q     <= mup_d;
            mdw_q     <= mdw_d;
            door_q    <= door_d;
        end
    end

    assign mup       = mup_q;
    assign mdw       = mdw_q;
    assign door_open = door_q;
    assign floor     = floor_q;
    assign pending   = pending_q;
    assign moving    = mup_q | mdw_q;

endmodule

// File: doc/elevador_npisos.md
ELEVADOR_NPISOS -- requirements
Module: elevador_npisos

Interface
REQ-001 Parameter FLOORS, default 4, number of served floors, legal range 2..16.
REQ-002 Parameter DOOR_CYCLES, default 8, clk cycles the door stays open, legal range 1..255.
REQ-003 Derived width FW = clog2(FLOORS), minimum 1.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  FLOORS  call buttons; bit i high for one or more cycles requests floor i.
REQ-007 fsens  input  FLOORS  floor sensors; bit i high while the cab is level with floor i.
REQ-008 mup  output  1  motor up command, registered.
REQ-009 mdw  output  1  motor down command, registered.
REQ-010 door_open  output  1  door open command, registered.
REQ-011 floor  output  FW  binary index of the last valid floor sensed, registered.
REQ-012 pending  output  FLOORS  latched outstanding requests, registered.
REQ-013 moving  output  1  equals mup OR mdw; drives the display blink enable.

Function
REQ-014 States: IDLE, UP, DN, DOOR; a direction flag dir (1 = up) is held in IDLE.
REQ-015 fsens valid = exactly one bit set; on valid fsens, floor loads that bit's index next edge; otherwise floor holds.
REQ-016 pending[i] sets on any cycle req[i]=1, except when the block is in DOOR, or entering DOOR, at floor i.
REQ-017 A req for floor i during DOOR at floor i is not latched and reloads the door timer to DOOR_CYCLES.
REQ-018 IDLE: if pending[floor] -> DOOR, clear pending[floor].
REQ-019 IDLE, else if requests are above floor and (dir=1 or none are below) -> UP, dir=1.
REQ-020 IDLE, else if requests are below floor -> DN, dir=0.
REQ-021 IDLE with no pending requests -> stay IDLE, all motor and door outputs low.
REQ-022 UP: mup=1 and mdw=0 on every cycle in state.
REQ-023 UP, valid fsens at floor f with pending[f]=1 -> DOOR; pending[f] clears; mup=0 from the next cycle (one-cycle stop latency).
REQ-024 UP, valid fsens at floor FLOORS-1 -> DOOR unconditionally (overtravel guard).
REQ-025 DN is the mirror of UP: mdw=1, stop on a pending floor or unconditionally at floor 0.
REQ-026 Floors passed without a pending request are not stopped at.
REQ-027 DOOR: door_open=1, mup=mdw=0; the timer counts down from DOOR_CYCLES; at expiry -> IDLE, door_open=0 next cycle.
REQ-028 With no re-requests, door_open is high for exactly DOOR_CYCLES consecutive cycles.
REQ-029 mup and mdw are never high together; door_open is never high together with mup or mdw.
REQ-030 Invalid fsens (zero bits or multiple bits) never causes a stop, a state change or a floor update.
REQ-031 Direction preference (SCAN): keep dir while requests exist ahead, reverse only when none remain ahead.

Reset
REQ-032 When reset=1 at an edge: state=IDLE, dir=1, floor=0, pending=0, mup=mdw=door_open=0, timer=0; this applies from any state, including mid-travel.
REQ-033 While reset is high, req input is ignored.
REQ-034 After reset the block assumes floor 0 until the first valid fsens.

Verification
REQ-035 FLOORS=4, cab at 0, req[3] pulse -> mup=1 within 2 cycles; fsens 0b0010 and 0b0100 pass without stop; fsens=0b1000 -> mup=0 next cycle, door_open high 8 cycles, pending=0.
REQ-036 Cab moving up from 0 with pending={1,3}, req[2] arriving mid-travel -> stops occur in order at 1, 2, 3; no reversal.
REQ-037 Cab at 2 with dir=1, pending={0,3} -> serves 3 first, then DN to 0.
REQ-038 In DOOR at floor 1, req[1] pulse on the 5th open cycle -> pending[1] stays 0; door_open stays high 8 cycles counted from the pulse.
REQ-039 Reset asserted during UP with mup=1 -> mup=0 and pending=0 next cycle; floor reads 0.
REQ-040 fsens=0b0110 during UP with pending[1]=1 -> no stop and floor unchanged; then fsens=0b0010 -> stop at 1; mup and mdw never high together across the whole run.
